// File: rtl/snn_pkg.sv
// ---------------------------------------------------------------------------
// snn_pkg
//
// Shared definitions for the spiking-network node. It holds the default
// sizing of the inter-board spike receiver and the encoding of the per-channel
// pending-queue update.
//
// Contents:
//   N_CH_DEFAULT    number of inter-board spike channels (spikein1..14)
//   CNT_W_DEFAULT   width of each channel's pending-spike counter
//   DROP_W_DEFAULT  width of the saturating drop counter
//   PEND_MAX        largest pending count with the default counter width
//   pend_op_e       what a channel does to its pending count this cycle
// ---------------------------------------------------------------------------
package snn_pkg;

    localparam int N_CH_DEFAULT   = 14;
    localparam int CNT_W_DEFAULT  = 4;
    localparam int DROP_W_DEFAULT = 16;

    localparam int PEND_MAX = (1 << CNT_W_DEFAULT) - 1;

    // Queue operations are kept as named actions so the channel logic reads
    // as "decide what to do", then "do it".
    typedef enum logic [1:0] {
        PEND_HOLD  = 2'd0,
        PEND_INC   = 2'd1,
        PEND_DEC   = 2'd2,
        PEND_CLEAR = 2'd3
    } pend_op_e;

endpackage

// File: rtl/spike_rx_chan.sv
// ---------------------------------------------------------------------------
// spike_rx_chan
//
// One inter-board spike channel. The raw asynchronous spike line is brought
// into the clk domain, its rising edges are queued in a pending counter, and
// on each neuron tick at most one queued spike is released as a level that
// holds until the next tick.
//
// Ports:
//   clk           fast clock; all state lives here
//   reset_global  asynchronous active-high reset
//   spikein_i     raw asynchronous spike line
//   enable_i      channel enable; when low, edges are ignored and the queue
//                 is emptied
//   tick_i        one-cycle pulse, once per neuron_clk period
//   clear_i       synchronous clear of the sticky overflow flag
//   spike_o       registered spike level to the synapse
//   overflow_o    sticky flag: an edge was lost on a full queue
//   ovf_evt_o     single-cycle pulse for each lost edge (feeds drop_count)
// ---------------------------------------------------------------------------
module spike_rx_chan
    import snn_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic clk,
    input  logic reset_global,
    input  logic spikein_i,
    input  logic enable_i,
    input  logic tick_i,
    input  logic clear_i,
    output logic spike_o,
    output logic overflow_o,
    output logic ovf_evt_o
);

    localparam logic [CNT_W-1:0] PendMax = {CNT_W{1'b1}};

    logic             sync1_q;
    logic             sync2_q;
    logic             hist_q;
    logic             edgeDet;
    logic [CNT_W-1:0] pend_q;
    logic [CNT_W-1:0] pend_d;
    logic             spike_q;
    logic             spike_d;
    logic             ovf_q;
    logic             ovf_d;
    logic             ovfEvt;
    pend_op_e         pendOp;

    // Two-flop synchronizer for the raw line, followed by a history flop so a
    // rising edge can be seen as "now high, previously low".
    always_ff @(posedge clk or posedge reset_global) begin
        if (reset_global) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            hist_q  <= 1'b0;
        end else begin
            sync1_q <= spikein_i;
            sync2_q <= sync1_q;
            hist_q  <= sync2_q;
        end
    end

    // A disabled channel sees no edges at all, so it can never queue,
    // release or overflow.
    assign edgeDet = sync2_q & ~hist_q & enable_i;

    // Decide what happens to the queue this cycle. An edge coinciding with a
    // tick cancels out: either one queued spike leaves while a new one joins,
    // or, with an empty queue, the new edge goes straight to the output.
    // That is why a full queue can only overflow when no tick is present.
    always_comb begin
        pendOp = PEND_HOLD;
        ovfEvt = 1'b0;
        if (!enable_i) begin
            pendOp = PEND_CLEAR;
        end else if (edgeDet && !tick_i) begin
            if (pend_q == PendMax) begin
                ovfEvt = 1'b1;
            end else begin
                pendOp = PEND_INC;
            end
        end else if (tick_i && !edgeDet && (pend_q != '0)) begin
            pendOp = PEND_DEC;
        end
    end

    // Apply the queue action, refresh the spike level on ticks only, and keep
    // the overflow flag sticky until cleared. A clear on the same cycle as a
    // new overflow still leaves the flag low.
    always_comb begin
        pend_d = pend_q;
        unique case (pendOp)
            PEND_INC:   pend_d = pend_q + 1'b1;
            PEND_DEC:   pend_d = pend_q - 1'b1;
            PEND_CLEAR: pend_d = '0;
            default:    pend_d = pend_q;
        endcase

        spike_d = spike_q;
        if (tick_i) begin
            spike_d = (pend_q != '0) | edgeDet;
        end

        ovf_d = clear_i ? 1'b0 : (ovf_q | ovfEvt);
    end

    // Channel state register; reset throws away anything still queued.
    always_ff @(posedge clk or posedge reset_global) begin
        if (reset_global) begin
            pend_q  <= '0;
            spike_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            pend_q  <= pend_d;
            spike_q <= spike_d;
            ovf_q   <= ovf_d;
        end
    end

    assign spike_o    = spike_q;
    assign overflow_o = ovf_q;
    assign ovf_evt_o  = ovfEvt;

endmodule

// File: rtl/spike_rx_bank.sv
// ---------------------------------------------------------------------------
// spike_rx_bank
//
// Inter-board spike receiver sitting between the FPGA-FPGA spike input pins
// and the synapse spike_in ports. Each line is synchronized and edge
// detected, edges are queued per channel, and one spike per channel per
// neuron_clk period is released as a level that is stable across the next
// neuron_clk rising edge. Edges lost on full queues are flagged and counted.
//
// Ports:
//   clk           fast clock (clk1); all state lives here
//   reset_global  asynchronous active-high reset, clears all state
//   neuron_clk    neuron clock, sampled as data
//   spikein       raw asynchronous spike lines, one per channel
//   ch_enable     per-channel enable
//   clear         synchronous pulse clearing overflow and drop_count
//   spike_out     registered spike levels to the synapses
//   overflow      sticky per-channel lost-edge flags
//   drop_count    saturating total of lost edges over all channels
// ---------------------------------------------------------------------------
module spike_rx_bank
    import snn_pkg::*;
#(
    parameter int N_CH   = N_CH_DEFAULT,
    parameter int CNT_W  = CNT_W_DEFAULT,
    parameter int DROP_W = DROP_W_DEFAULT
) (
    input  logic              clk,
    input  logic              reset_global,
    input  logic              neuron_clk,
    input  logic [N_CH-1:0]   spikein,
    input  logic [N_CH-1:0]   ch_enable,
    input  logic              clear,
    output logic [N_CH-1:0]   spike_out,
    output logic [N_CH-1:0]   overflow,
    output logic [DROP_W-1:0] drop_count
);

    localparam int PC_W  = $clog2(N_CH + 1);
    localparam int SUM_W = DROP_W + PC_W;
    localparam logic [DROP_W-1:0] DropMax = {DROP_W{1'b1}};

    logic              nclkSync1_q;
    logic              nclkSync2_q;
    logic              nclkHist_q;
    logic              tick;
    logic [N_CH-1:0]   ovfEvt;
    logic [PC_W-1:0]   ovfCount;
    logic [SUM_W-1:0]  dropSum;
    logic [DROP_W-1:0] drop_q;
    logic [DROP_W-1:0] drop_d;

    // neuron_clk is only ever treated as data: synchronize it and keep one
    // extra sample so its falling edge can be spotted.
    always_ff @(posedge clk or posedge reset_global) begin
        if (reset_global) begin
            nclkSync1_q <= 1'b0;
            nclkSync2_q <= 1'b0;
            nclkHist_q  <= 1'b0;
        end else begin
            nclkSync1_q <= neuron_clk;
            nclkSync2_q <= nclkSync1_q;
            nclkHist_q  <= nclkSync2_q;
        end
    end

    // Ticking on the falling edge puts the spike_out update mid-period, so
    // the released level has half a period of margin before the neuron_clk
    // rising edge that the synapses sample on.
    assign tick = nclkHist_q & ~nclkSync2_q;

    // One receiver per inter-board spike line.
    for (genvar g = 0; g < N_CH; g++) begin : g_chan
        spike_rx_chan #(
            .CNT_W (CNT_W)
        ) u_chan (
            .clk          (clk),
            .reset_global (reset_global),
            .spikein_i    (spikein[g]),
            .enable_i     (ch_enable[g]),
            .tick_i       (tick),
            .clear_i      (clear),
            .spike_o      (spike_out[g]),
            .overflow_o   (overflow[g]),
            .ovf_evt_o    (ovfEvt[g])
        );
    end

    // Several channels can drop an edge in the same cycle, so the counter
    // advances by the number of simultaneous drops and pins at its maximum
    // instead of wrapping. clear has priority over any drops that cycle.
    always_comb begin
        ovfCount = '0;
        for (int i = 0; i < N_CH; i++) begin
            ovfCount = ovfCount + PC_W'(ovfEvt[i]);
        end

        dropSum = SUM_W'(drop_q) + SUM_W'(ovfCount);

        drop_d = drop_q;
        if (clear) begin
            drop_d = '0;
        end else if (dropSum > SUM_W'(DropMax)) begin
            drop_d = DropMax;
        end else begin
            drop_d = dropSum[DROP_W-1:0];
        end
    end

    // Drop counter register.
    always_ff @(posedge clk or posedge reset_global) begin
        if (reset_global) begin
            drop_q <= '0;
        end else begin
            drop_q <= drop_d;
        end
    end

    assign drop_count = drop_q;

endmodule
